// File: rtl/star_pkg.sv
// star_pkg
// Shared definitions for the star collector: default parameter values and
// the encoding of the credit FSM.
//   DEF_NUM_STARS    : number of collectible stars (one touch bit per star)
//   DEF_POINTS_TENS  : BCD tens-digit increment credited per star
//   DEF_FLASH_CYCLES : length of the collect flash pulse in cycles
//   star_state_t     : IDLE (nothing to credit), ADD (crediting), DONE (all collected)
package star_pkg;

    localparam int DEF_NUM_STARS    = 5;
    localparam int DEF_POINTS_TENS  = 5;
    localparam int DEF_FLASH_CYCLES = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } star_state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add
// Adds one BCD digit, a 4-bit addend and a carry-in, producing a corrected
// BCD digit and a decimal carry-out.
//   digit_in  : current BCD digit (0..9)
//   addend    : value to add (0..9)
//   carry_in  : carry from the next lower digit
//   digit_out : resulting BCD digit (0..9)
//   carry_out : set when the decimal sum reached 10 or more
module bcd_digit_add
    import star_pkg::*;
(
    input  logic [3:0] digit_in,
    input  logic [3:0] addend,
    input  logic       carry_in,
    output logic [3:0] digit_out,
    output logic       carry_out
);

    logic [4:0] raw_sum;

    always_comb begin
        raw_sum = {1'b0, digit_in} + {1'b0, addend} + {4'b0000, carry_in};
        if (raw_sum > 5'd9) begin
            digit_out = 4'(raw_sum - 5'd10);
            carry_out = 1'b1;
        end else begin
            digit_out = raw_sum[3:0];
            carry_out = 1'b0;
        end
    end

endmodule

// File: rtl/star_collector.sv
// star_collector
// Tracks which stars have been collected, credits points for each one in
// BCD (one star per cycle), drives a retriggerable flash pulse per credit and
// flags when every star has been collected and credited.
//   sys_clk       : system clock, rising edge
//   RST_N         : asynchronous active-low reset
//   touch_star    : per-star one-cycle touch pulses
//   game_start    : synchronous clear of all collection state
//   star_en       : per-star still-collectible flag
//   star_count    : number of stars collected
//   score_bcd     : three-digit BCD score, hundreds in [11:8]
//   flash         : collect-flash effect active
//   all_collected : every star collected and all points credited
module star_collector
    import star_pkg::*;
#(
    parameter int NUM_STARS    = DEF_NUM_STARS,
    parameter int POINTS_TENS  = DEF_POINTS_TENS,
    parameter int FLASH_CYCLES = DEF_FLASH_CYCLES
) (
    input  logic                 sys_clk,
    input  logic                 RST_N,
    input  logic [NUM_STARS-1:0] touch_star,
    input  logic                 game_start,
    output logic [NUM_STARS-1:0] star_en,
    output logic [2:0]           star_count,
    output logic [11:0]          score_bcd,
    output logic                 flash,
    output logic                 all_collected
);

    localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);

    star_state_t          state, state_next;
    logic [NUM_STARS-1:0] collected_mask, mask_next, new_touch;
    logic [2:0]           pending, pending_next;
    logic [3:0]           tens_digit, tens_next, tens_sum;
    logic [3:0]           hundreds_digit, hundreds_next, hundreds_sum;
    logic                 tens_carry, unused_hundreds_carry;
    logic [FLASH_W-1:0]   flash_cnt, flash_next;
    logic                 credit;

    function automatic logic [2:0] count_ones(input logic [NUM_STARS-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < NUM_STARS; i++) begin
            c = c + 3'(v[i]);
        end
        return c;
    endfunction

    // The ones digit is always zero, so only tens and hundreds need adders.
    bcd_digit_add u_tens (
        .digit_in  (tens_digit),
        .addend    (4'(POINTS_TENS)),
        .carry_in  (1'b0),
        .digit_out (tens_sum),
        .carry_out (tens_carry)
    );

    bcd_digit_add u_hundreds (
        .digit_in  (hundreds_digit),
        .addend    (4'h0),
        .carry_in  (tens_carry),
        .digit_out (hundreds_sum),
        .carry_out (unused_hundreds_carry)
    );

    // Pending is nonzero exactly while in ADD, so ADD credits every cycle.
    // IDLE moves to ADD on the same edge the touch lands in pending, which
    // lets the first credit show up two cycles after the touch.
    always_comb begin
        new_touch     = (state == ST_DONE) ? '0 : (touch_star & ~collected_mask);
        credit        = (state == ST_ADD);
        mask_next     = collected_mask | new_touch;
        pending_next  = pending + count_ones(new_touch) - {2'b00, credit};
        tens_next     = credit ? tens_sum : tens_digit;
        hundreds_next = credit ? hundreds_sum : hundreds_digit;
        if (credit) begin
            flash_next = FLASH_W'(FLASH_CYCLES);
        end else if (flash_cnt != '0) begin
            flash_next = flash_cnt - FLASH_W'(1);
        end else begin
            flash_next = '0;
        end
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pending_next != 3'd0) begin
                    state_next = ST_ADD;
                end
            end
            ST_ADD: begin
                if (pending_next == 3'd0) begin
                    state_next = (&mask_next) ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
        if (game_start) begin
            mask_next     = '0;
            pending_next  = '0;
            tens_next     = '0;
            hundreds_next = '0;
            flash_next    = '0;
            state_next    = ST_IDLE;
        end
    end

    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            state          <= ST_IDLE;
            collected_mask <= '0;
            pending        <= '0;
            tens_digit     <= '0;
            hundreds_digit <= '0;
            flash_cnt      <= '0;
        end else begin
            state          <= state_next;
            collected_mask <= mask_next;
            pending        <= pending_next;
            tens_digit     <= tens_next;
            hundreds_digit <= hundreds_next;
            flash_cnt      <= flash_next;
        end
    end

    assign star_en       = ~collected_mask;
    assign star_count    = count_ones(collected_mask);
    assign score_bcd     = {hundreds_digit, tens_digit, 4'h0};
    assign flash         = (flash_cnt != '0);
    assign all_collected = (state == ST_DONE);

endmodule

// File: doc/star_collector.md
STAR_COLLECTOR -- requirements
Module: star_collector

Interface
REQ-001 Parameter NUM_STARS, default 5: number of collectible stars, one touch input bit per star.
REQ-002 Parameter POINTS_TENS, default 5: BCD tens-digit increment per star (+50 points); legal range 1..9.
REQ-003 Parameter FLASH_CYCLES, default 8: length in cycles of the collect flash pulse.
REQ-004 sys_clk  input  1  system clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 touch_star  input  NUM_STARS  per-star one-cycle touch pulses from the star objects.
REQ-007 game_start  input  1  synchronous one-cycle clear of all collection state.
REQ-008 star_en  output  NUM_STARS  per-star still-collectible flag (1 = not yet collected).
REQ-009 star_count  output  3  number of stars collected.
REQ-010 score_bcd  output  12  three-digit BCD score, hundreds in [11:8].
REQ-011 flash  output  1  high while the collect-flash effect is active.
REQ-012 all_collected  output  1  level; high when every star is collected and all points are credited.

Function
REQ-013 New touches SHALL be new = touch_star & ~collected_mask; touches on already-collected stars are ignored.
REQ-014 At the edge after a touch in cycle N, collected_mask SHALL OR in new, star_en SHALL equal ~collected_mask, and star_count SHALL equal popcount(collected_mask), all visible in cycle N+1.
REQ-015 Pending counter (3 bits) SHALL add popcount(new) and subtract 1 per credit in the same edge; simultaneous touches on several stars SHALL all be counted.
REQ-016 FSM states: IDLE, ADD, DONE.
REQ-017 IDLE -> ADD when pending becomes nonzero; ADD stays while pending > 0 after update; ADD -> IDLE when pending reaches 0 and mask != all ones; ADD -> DONE when pending reaches 0 and mask == all ones.
REQ-018 In ADD, each cycle SHALL credit exactly one star: score_bcd += POINTS_TENS*10 with BCD carry tens->hundreds; first credit occurs in cycle N+2 after touch cycle N.
REQ-019 Maximum score is NUM_STARS*POINTS_TENS*10 <= 450; no saturation logic required; hundreds digit never exceeds 4.
REQ-020 Each credit SHALL load flash counter with FLASH_CYCLES; flash = (counter != 0); counter decrements each cycle; a credit while flashing SHALL reload (retrigger).
REQ-021 all_collected SHALL be high exactly while the FSM is in DONE.
REQ-022 In DONE, touch_star SHALL be ignored; only game_start or reset exits.
REQ-023 game_start SHALL clear mask, pending, score, flash counter and return the FSM to IDLE at the next edge, taking priority over touches and credits in the same cycle.
REQ-024 A touch arriving while in ADD SHALL be merged into pending with no loss.

Reset
REQ-025 With RST_N low: collected_mask=0, star_en=all ones, star_count=0, score_bcd=12'h000, pending=0, flash counter=0, flash=0, FSM=IDLE, all_collected=0.
REQ-026 Reset mid-ADD SHALL discard uncredited pending points; score after reset is 000.

Structure
REQ-027 Shared package star_pkg SHALL hold NUM_STARS, POINTS_TENS, FLASH_CYCLES defaults and the FSM state encoding.
REQ-028 One sub-module bcd_digit_add (4-bit digit + 4-bit addend + carry-in -> digit + carry-out) SHALL be instantiated for the tens and hundreds digits.

Verification
REQ-029 Touch star0 at cycle 10 -> star_en=5'b11110 and star_count=1 at cycle 11; score_bcd=12'h050 and flash=1 at cycle 12; flash low at cycle 20.
REQ-030 touch_star=5'b10101 in one cycle -> star_count=3 next cycle; score goes 050, 100, 150 in three consecutive cycles; flash held through the last credit +8 cycles.
REQ-031 Re-touch an already-collected star -> no change to pending, score or flash.
REQ-032 Collect all 5 stars -> score_bcd=12'h250, all_collected=1 after final credit; later touches ignored.
REQ-033 game_start asserted in the same cycle as a touch during ADD -> next cycle score=000, star_en=all ones, pending=0, FSM=IDLE.
REQ-034 RST_N low asynchronously mid-ADD -> all outputs at reset values immediately, without waiting for a clock edge.
